int_sched: RTL and testbench

Interrupt scheduler for the 8051 core: it polls the five interrupt sources against IE/IP and selects one by fixed priority. It presents a vectored request to the CPU and handles the accept handshake. It also tracks the two-level in-service nesting state and issues hardware flag clears back to TCON. It sits between the SFR file (IE, IP, TCON, SCON flags) and the CPU's instruction-boundary / LCALL sequencer.

---
 rtl/int_sched.sv | 155 +++++++++++++++
 tb/tb_int_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sched.sv
// int_sched : interrupt scheduler for the 8051 core.
//
// Samples the five interrupt flags against IE/EA every clock and picks one
// source by fixed priority, high-priority level first. At an instruction
// boundary it presents a vectored request to the CPU. The request is held
// until the CPU accepts it. On accept, the scheduler marks the level as in
// service and pulses the hardware clear for the timer or external flag. RETI
// pops the in-service nesting state, high level first.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   ie            IE SFR: bit7 EA, bits4:0 enables {ES, ET1, EX1, ET0, EX0}
//   ip            IP SFR: bits4:0 priority (1 = high) for the same sources
//   flags         raw level flags {RI|TI, TF1, IE1, TF0, IE0}
//   it            {IT1, IT0}; 1 = edge-triggered external interrupt
//   inst_boundary last cycle of an instruction (poll point)
//   block         instruction at this boundary is RETI or an IE/IP write
//   cpu_ack       one-cycle pulse: CPU took the vector
//   reti          one-cycle pulse: CPU executed RETI
//   irq_valid     request pending toward the CPU
//   irq_vector    vector address, stable while irq_valid
//   irq_src       source index 0..4 of the pending request
//   clr_flag      one-cycle hardware clear {TF1, IE1, TF0, IE0}
//   in_service    {high_active, low_active}
module int_sched #(
   parameter logic [15:0] VEC_BASE = 16'h0003
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  ie,
   input  logic [7:0]  ip,
   input  logic [4:0]  flags,
   input  logic [1:0]  it,
   input  logic        inst_boundary,
   input  logic        block,
   input  logic        cpu_ack,
   input  logic        reti,
   output logic        irq_valid,
   output logic [15:0] irq_vector,
   output logic [2:0]  irq_src,
   output logic [3:0]  clr_flag,
   output logic [1:0]  in_service
);

   typedef enum logic {S_IDLE, S_PEND} state_t;

   state_t      r_state;
   logic [4:0]  r_req_q;
   logic        r_lvl;      // level of the committed request (1 = high)

   logic [4:0]  w_hi_req;
   logic [4:0]  w_lo_req;
   logic        w_cand_any;
   logic        w_cand_hi;
   logic [2:0]  w_cand_src;
   logic        w_eligible;
   logic [15:0] w_cand_vec;
   logic [1:0]  w_ins_pop;
   logic        w_unused;

   // IE bits 6:5 and IP bits 7:5 are reserved in this core.
   assign w_unused = ^{ie[6:5], ip[7:5]};

   // Lowest index wins: IE0 > TF0 > IE1 > TF1 > serial.
   function automatic logic [2:0] f_lowest(input logic [4:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   assign w_hi_req = r_req_q & ip[4:0];
   assign w_lo_req = r_req_q & ~ip[4:0];

   always_comb begin
      w_cand_any = 1'b0;
      w_cand_hi  = 1'b0;
      w_cand_src = 3'd0;
      if (|w_hi_req) begin
         w_cand_any = 1'b1;
         w_cand_hi  = 1'b1;
         w_cand_src = f_lowest(w_hi_req);
      end else if (|w_lo_req) begin
         w_cand_any = 1'b1;
         w_cand_src = f_lowest(w_lo_req);
      end
   end

   // A candidate may only interrupt something of strictly lower level.
   assign w_eligible = w_cand_any &
                       (w_cand_hi ? ~in_service[1] : (in_service == 2'b00));

   assign w_cand_vec = VEC_BASE + {10'd0, w_cand_src, 3'b000};

   // RETI pops the innermost level. The ack set is applied on top of this,
   // so a same-cycle reti + ack leaves the acked level marked.
   always_comb begin
      w_ins_pop = in_service;
      if (reti) begin
         if (in_service[1])      w_ins_pop[1] = 1'b0;
         else if (in_service[0]) w_ins_pop[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_req_q    <= 5'd0;
         r_lvl      <= 1'b0;
         irq_valid  <= 1'b0;
         irq_vector <= 16'h0000;
         irq_src    <= 3'd0;
         clr_flag   <= 4'd0;
         in_service <= 2'b00;
      end else begin
         r_req_q    <= flags & ie[4:0] & {5{ie[7]}};
         clr_flag   <= 4'd0;
         in_service <= w_ins_pop;
         case (r_state)
            S_IDLE: begin
               if (inst_boundary && !block && w_eligible) begin
                  r_state    <= S_PEND;
                  irq_valid  <= 1'b1;
                  irq_src    <= w_cand_src;
                  irq_vector <= w_cand_vec;
                  r_lvl      <= w_cand_hi;
               end
            end
            S_PEND: begin
               // Committed: source and vector are held regardless of flags.
               if (cpu_ack) begin
                  r_state   <= S_IDLE;
                  irq_valid <= 1'b0;
                  if (r_lvl) in_service <= w_ins_pop | 2'b10;
                  else       in_service <= w_ins_pop | 2'b01;
                  // External flags are only cleared when edge-triggered;
                  // the serial flag is left to software.
                  case (irq_src)
                     3'd0:    clr_flag <= {3'b000, it[0]};
                     3'd1:    clr_flag <= 4'b0010;
                     3'd2:    clr_flag <= {1'b0, it[1], 2'b00};
                     3'd3:    clr_flag <= 4'b1000;
                     default: clr_flag <= 4'b0000;
                  endcase
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_int_sched.sv
// Bench for int_sched: directed scenarios followed by random traffic, with
// every output compared each cycle against a behavioural model.
module tb_int_sched;

   logic        clk;
   logic        reset;
   logic [7:0]  ie;
   logic [7:0]  ip;
   logic [4:0]  flags;
   logic [1:0]  it;
   logic        inst_boundary;
   logic        block;
   logic        cpu_ack;
   logic        reti;
   logic        irq_valid;
   logic [15:0] irq_vector;
   logic [2:0]  irq_src;
   logic [3:0]  clr_flag;
   logic [1:0]  in_service;

   int n_assert = 0;
   int n_fail   = 0;

   // behavioural model state
   logic [4:0] m_req;
   bit         m_pend;
   int         m_src;
   bit         m_lvl;
   bit         m_hi, m_lo;
   logic [3:0] m_clr;

   int_sched #(.VEC_BASE(16'h0003)) dut (
      .clk(clk), .reset(reset), .ie(ie), .ip(ip), .flags(flags), .it(it),
      .inst_boundary(inst_boundary), .block(block), .cpu_ack(cpu_ack),
      .reti(reti), .irq_valid(irq_valid), .irq_vector(irq_vector),
      .irq_src(irq_src), .clr_flag(clr_flag), .in_service(in_service)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_req = 5'd0; m_pend = 0; m_src = 0; m_lvl = 0;
      m_hi = 0; m_lo = 0; m_clr = 4'd0;
   endtask

   // One clock edge of the scheduler, from the rules: priority search over
   // the sampled requests, level comparison, commit, accept and RETI pop.
   task automatic model_edge();
      int cand;
      bit ch, ohi, olo;
      cand = -1; ch = 0; ohi = m_hi; olo = m_lo;
      for (int k = 0; k < 5; k++)
         if (cand < 0 && m_req[k] && ip[k]) begin cand = k; ch = 1; end
      for (int k = 0; k < 5; k++)
         if (cand < 0 && m_req[k] && !ip[k]) cand = k;
      m_clr = 4'd0;
      if (reti) begin
         if (m_hi) m_hi = 0;
         else      m_lo = 0;
      end
      if (m_pend) begin
         if (cpu_ack) begin
            m_pend = 0;
            if (m_lvl) m_hi = 1; else m_lo = 1;
            if (m_src == 1) m_clr[1] = 1'b1;
            if (m_src == 3) m_clr[3] = 1'b1;
            if (m_src == 0) m_clr[0] = it[0];
            if (m_src == 2) m_clr[2] = it[1];
         end
      end else if (inst_boundary && !block && cand >= 0 &&
                   (ch ? !ohi : (!ohi && !olo))) begin
         m_pend = 1; m_src = cand; m_lvl = ch;
      end
      m_req = ie[7] ? (flags & ie[4:0]) : 5'd0;
   endtask

   task automatic check_model();
      logic [15:0] ev;
      ev = 16'h0003 + 16'(8 * m_src);
      chk("m_valid", {31'd0, irq_valid}, {31'd0, m_pend});
      if (m_pend) begin
         chk("m_vector", {16'd0, irq_vector}, {16'd0, ev});
         chk("m_src", {29'd0, irq_src}, 32'(m_src));
      end
      chk("m_clr", {28'd0, clr_flag}, {28'd0, m_clr});
      chk("m_ins", {30'd0, in_service}, {30'd0, m_hi, m_lo});
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   initial begin
      reset = 1'b1; ie = 8'h00; ip = 8'h00; flags = 5'd0; it = 2'b00;
      inst_boundary = 0; block = 0; cpu_ack = 0; reti = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, irq_valid}, 32'd0);
      chk("rst_vector", {16'd0, irq_vector}, 32'h0);
      chk("rst_src", {29'd0, irq_src}, 32'd0);
      chk("rst_clr", {28'd0, clr_flag}, 32'd0);
      chk("rst_ins", {30'd0, in_service}, 32'd0);
      reset = 1'b0;

      // single low source IE0, edge-triggered
      ie = 8'h81; ip = 8'h00; flags = 5'b00001; it = 2'b01;
      cyc();
      inst_boundary = 1; cyc(); inst_boundary = 0;
      chk("t1_valid", {31'd0, irq_valid}, 32'd1);
      chk("t1_vec", {16'd0, irq_vector}, 32'h0003);
      chk("t1_src", {29'd0, irq_src}, 32'd0);
      cpu_ack = 1; cyc(); cpu_ack = 0;
      chk("t1_valid_lo", {31'd0, irq_valid}, 32'd0);
      chk("t1_clr", {28'd0, clr_flag}, 32'b0001);
      chk("t1_ins", {30'd0, in_service}, 32'b01);
      cyc();
      chk("t1_clr_once", {28'd0, clr_flag}, 32'd0);
      flags = 5'd0; reti = 1; cyc(); reti = 0;
      chk("t1_pop", {30'd0, in_service}, 32'b00);

      // TF0 and serial together, both low
      ie = 8'h92; flags = 5'b10010;
      cyc();
      inst_boundary = 1; cyc(); inst_boundary = 0;
      chk("t2_vec", {16'd0, irq_vector}, 32'h000B);
      chk("t2_src", {29'd0, irq_src}, 32'd1);
      cpu_ack = 1; cyc(); cpu_ack = 0;
      chk("t2_clr", {28'd0, clr_flag}, 32'b0010);
      flags = 5'd0; reti = 1; cyc(); reti = 0;

      // nesting: TF1 low in service, then high IE0 (level-triggered)
      ie = 8'h88; flags = 5'b01000;
      cyc();
      inst_boundary = 1; cyc(); inst_boundary = 0;
      cpu_ack = 1; cyc(); cpu_ack = 0;
      chk("t3_tf1_clr", {28'd0, clr_flag}, 32'b1000);
      chk("t3_ins_lo", {30'd0, in_service}, 32'b01);
      flags = 5'd0;
      ie = 8'h89; ip = 8'h01; flags = 5'b00001; it = 2'b00;
      cyc();
      inst_boundary = 1; cyc(); inst_boundary = 0;
      chk("t3_nest_vec", {16'd0, irq_vector}, 32'h0003);
      cpu_ack = 1; cyc(); cpu_ack = 0;
      chk("t3_ins_11", {30'd0, in_service}, 32'b11);
      chk("t3_lvl_noclr", {28'd0, clr_flag}, 32'd0);
      flags = 5'd0; reti = 1; cyc(); reti = 0;
      chk("t3_pop_hi", {30'd0, in_service}, 32'b01);
      ip = 8'h00; ie = 8'h8A; flags = 5'b00010;
      cyc();
      inst_boundary = 1; cyc(); cyc(); inst_boundary = 0;
      chk("t3_low_blocked", {31'd0, irq_valid}, 32'd0);
      flags = 5'd0; cyc();
      reti = 1; cyc(); reti = 0;
      chk("t3_pop_lo", {30'd0, in_service}, 32'b00);

      // block suppresses only its own boundary
      ie = 8'h81; ip = 8'h00; flags = 5'b00001;
      cyc();
      inst_boundary = 1; block = 1; cyc();
      chk("t4_blocked", {31'd0, irq_valid}, 32'd0);
      block = 0; cyc(); inst_boundary = 0;
      chk("t4_next", {31'd0, irq_valid}, 32'd1);
      cpu_ack = 1; cyc(); cpu_ack = 0;
      flags = 5'd0; reti = 1; cyc(); reti = 0;
      // EA = 0
      ie = 8'h01; flags = 5'b00001; inst_boundary = 1;
      cyc(); cyc(); cyc();
      chk("t4_ea0", {31'd0, irq_valid}, 32'd0);
      inst_boundary = 0; flags = 5'd0;

      // commit hold, then RETI pops 11 -> 01 -> 00 -> 00
      ie = 8'h88; ip = 8'h00; flags = 5'b01000;
      cyc();
      inst_boundary = 1; cyc(); inst_boundary = 0;
      cpu_ack = 1; cyc(); cpu_ack = 0;
      flags = 5'd0;
      ie = 8'h89; ip = 8'h01; flags = 5'b00001;
      cyc();
      inst_boundary = 1; cyc();
      flags = 5'd0; ie = 8'h00;
      cyc(); cyc(); cyc(); inst_boundary = 0;
      chk("t5_held_valid", {31'd0, irq_valid}, 32'd1);
      chk("t5_held_vec", {16'd0, irq_vector}, 32'h0003);
      cpu_ack = 1; cyc(); cpu_ack = 0;
      chk("t5_ins_11", {30'd0, in_service}, 32'b11);
      reti = 1; cyc();
      chk("t5_pop1", {30'd0, in_service}, 32'b01);
      cyc();
      chk("t5_pop2", {30'd0, in_service}, 32'b00);
      cyc(); reti = 0;
      chk("t5_pop3", {30'd0, in_service}, 32'b00);

      // same-cycle reti + ack with low in service and a high request
      ie = 8'h88; ip = 8'h00; flags = 5'b01000;
      cyc();
      inst_boundary = 1; cyc(); inst_boundary = 0;
      cpu_ack = 1; cyc(); cpu_ack = 0;
      flags = 5'd0;
      ie = 8'h81; ip = 8'h01; flags = 5'b00001;
      cyc();
      inst_boundary = 1; cyc(); inst_boundary = 0;
      chk("t6_valid", {31'd0, irq_valid}, 32'd1);
      cpu_ack = 1; reti = 1; cyc(); cpu_ack = 0; reti = 0;
      chk("t6_ins_10", {30'd0, in_service}, 32'b10);

      // asynchronous reset while pending
      reti = 1; cyc(); reti = 0;
      inst_boundary = 1; cyc(); inst_boundary = 0;
      chk("t7_pend", {31'd0, irq_valid}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t7_valid", {31'd0, irq_valid}, 32'd0);
      chk("t7_vector", {16'd0, irq_vector}, 32'h0);
      chk("t7_src", {29'd0, irq_src}, 32'd0);
      chk("t7_clr", {28'd0, clr_flag}, 32'd0);
      chk("t7_ins", {30'd0, in_service}, 32'd0);
      #1 reset = 1'b0;
      model_reset();
      flags = 5'd0; cpu_ack = 1;
      cyc(); cpu_ack = 0;

      // random traffic against the model
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            ie = 8'($urandom);
            if ($urandom_range(0, 3) != 0) ie[7] = 1'b1;
            ip = 8'($urandom);
            it = 2'($urandom);
         end
         flags         = 5'($urandom);
         inst_boundary = ($urandom_range(0, 1) == 1);
         block         = ($urandom_range(0, 4) == 0);
         cpu_ack       = ($urandom_range(0, 2) == 0);
         reti          = ($urandom_range(0, 5) == 0);
         cyc();
      end
      inst_boundary = 0; block = 0; cpu_ack = 0; reti = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
